joltage_stream: RTL and testbench

Streaming, parametrised successor to the fixed-length joltage picker. Accepts battery-bank digits one per cycle over a valid/ready handshake, with variable line length up to `MAX_LEN`. After each line it computes the maximum `K_A`-digit and `K_B`-digit ordered subsequences. It reports the per-line values and running totals, and sits between the input line parser and the result/UART reporting stage.

---
 rtl/joltage_stream.sv | 194 +++++++++++++++++++
 tb/tb_joltage_stream.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joltage_stream.sv
// joltage_stream: buffers one line of digits, then finds the largest K_A- and K_B-digit subsequences.
// Optional macro JOLTAGE_SAT_EN: accumulators saturate instead of wrapping.
module joltage_stream #(
  parameter int MAX_LEN = 128,
  parameter int K_A     = 2,
  parameter int K_B     = 12,
  parameter int ACC_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             s_valid,
  input  logic [3:0]       s_digit,
  input  logic             s_last,
  output logic             s_ready,
  output logic             busy,
  output logic             res_valid,
  output logic [ACC_W-1:0] res_a,
  output logic [ACC_W-1:0] res_b,
  output logic             res_err,
  output logic [ACC_W-1:0] acc_a,
  output logic [ACC_W-1:0] acc_b,
  output logic [31:0]      line_cnt
);
  // state | meaning
  // IDLE  | accept digits into the line buffer
  // LOAD  | preload both chains with the line tail, set pointer, flag short line
  // SCAN  | feed buf[p] into the chains, p counting down to 0
  // DONE  | report per-line values, update accumulators and line count

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_t;
  state_t r_state, w_state_nx;

  logic [3:0]       r_buf [MAX_LEN];
  logic [3:0]       r_ca [K_A];
  logic [3:0]       w_ca_nx [K_A];
  logic [3:0]       r_cb [K_B];
  logic [3:0]       w_cb_nx [K_B];
  logic [PW-1:0]    r_n;
  logic [AW-1:0]    r_p;
  logic             r_ovf, r_short;
  logic [ACC_W-1:0] r_res_a, r_res_b, r_acc_a, r_acc_b;
  logic [ACC_W-1:0] w_val_a, w_val_b, w_acc_a_nx, w_acc_b_nx;
  logic [31:0]      r_line_cnt;
  logic             w_accept, w_short_ld, w_err, w_b_en, w_en_a, w_en_b;
  logic [3:0]       w_d;

  assign w_accept   = s_valid & (r_state == S_IDLE);
  assign w_short_ld = r_n < PW'(K_B);
  assign w_err      = r_short | r_ovf;
  assign w_d        = r_buf[r_p];
  // chain B only sees digits left of its preloaded window
  assign w_b_en     = PW'(r_p) < (r_n - PW'(K_B));

  assign acc_a    = r_acc_a;
  assign acc_b    = r_acc_b;
  assign line_cnt = r_line_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    s_ready    = 1'b0;
    busy       = 1'b1;
    res_valid  = 1'b0;
    res_err    = 1'b0;
    res_a      = r_res_a;
    res_b      = r_res_b;
    case (r_state)
      S_IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (w_accept && s_last) w_state_nx = S_LOAD;
      end
      S_LOAD: begin
        if (w_short_ld || r_ovf || r_n == PW'(K_A)) w_state_nx = S_DONE;
        else                                        w_state_nx = S_SCAN;
      end
      S_SCAN: if (r_p == '0) w_state_nx = S_DONE;
      S_DONE: begin
        w_state_nx = S_IDLE;
        res_valid  = 1'b1;
        res_err    = w_err;
        res_a      = w_err ? '0 : w_val_a;
        res_b      = w_err ? '0 : w_val_b;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_en_a     = w_d >= r_ca[0];
    w_ca_nx[0] = w_en_a ? w_d : r_ca[0];
    for (int i = 1; i < K_A; i++) begin
      w_en_a     = w_en_a & (r_ca[i-1] >= r_ca[i]);
      w_ca_nx[i] = w_en_a ? r_ca[i-1] : r_ca[i];
    end
    w_en_b     = w_d >= r_cb[0];
    w_cb_nx[0] = w_en_b ? w_d : r_cb[0];
    for (int i = 1; i < K_B; i++) begin
      w_en_b     = w_en_b & (r_cb[i-1] >= r_cb[i]);
      w_cb_nx[i] = w_en_b ? r_cb[i-1] : r_cb[i];
    end
  end

  always_comb begin
    w_val_a = '0;
    for (int i = 0; i < K_A; i++) w_val_a = (w_val_a << 3) + (w_val_a << 1) + ACC_W'(r_ca[i]);
    w_val_b = '0;
    for (int i = 0; i < K_B; i++) w_val_b = (w_val_b << 3) + (w_val_b << 1) + ACC_W'(r_cb[i]);
  end

`ifdef JOLTAGE_SAT_EN
  logic [ACC_W:0] w_sum_a, w_sum_b;
  always_comb begin
    w_sum_a    = {1'b0, r_acc_a} + {1'b0, w_val_a};
    w_sum_b    = {1'b0, r_acc_b} + {1'b0, w_val_b};
    w_acc_a_nx = w_sum_a[ACC_W] ? '1 : w_sum_a[ACC_W-1:0];
    w_acc_b_nx = w_sum_b[ACC_W] ? '1 : w_sum_b[ACC_W-1:0];
  end
`else
  always_comb begin
    w_acc_a_nx = r_acc_a + w_val_a;
    w_acc_b_nx = r_acc_b + w_val_b;
  end
`endif

  always_ff @(posedge clk) begin
    if (w_accept && r_n < PW'(MAX_LEN)) r_buf[AW'(r_n)] <= s_digit;
  end

  // chain contents are don't-care outside LOAD/SCAN, so no reset
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      for (int i = 0; i < K_A; i++) r_ca[i] <= r_buf[AW'(r_n - PW'(K_A - i))];
      for (int i = 0; i < K_B; i++) r_cb[i] <= r_buf[AW'(r_n - PW'(K_B - i))];
    end else if (r_state == S_SCAN) begin
      r_ca <= w_ca_nx;
      if (w_b_en) r_cb <= w_cb_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n        <= '0;
      r_p        <= '0;
      r_ovf      <= 1'b0;
      r_short    <= 1'b0;
      r_res_a    <= '0;
      r_res_b    <= '0;
      r_acc_a    <= '0;
      r_acc_b    <= '0;
      r_line_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_acc_a    <= '0;
            r_acc_b    <= '0;
            r_line_cnt <= '0;
          end
          if (w_accept) begin
            if (r_n < PW'(MAX_LEN)) r_n   <= r_n + PW'(1);
            else                    r_ovf <= 1'b1;
          end
        end
        S_LOAD: begin
          r_short <= w_short_ld;
          r_p     <= AW'(r_n - PW'(K_A + 1));
        end
        S_SCAN: r_p <= r_p - AW'(1);
        S_DONE: begin
          r_res_a    <= w_err ? '0 : w_val_a;
          r_res_b    <= w_err ? '0 : w_val_b;
          r_line_cnt <= r_line_cnt + 32'd1;
          if (!w_err) begin
            r_acc_a <= w_acc_a_nx;
            r_acc_b <= w_acc_b_nx;
          end
          r_n     <= '0;
          r_ovf   <= 1'b0;
          r_short <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_joltage_stream.sv
// Bench for joltage_stream: default, MAX_LEN=16 and ACC_W=8/K=2 instances, scoreboard of per-line results.
module tb_joltage_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clear, s_last;
  logic [3:0] s_digit;
  logic [2:0] s_valid;

  logic rdy0, busy0, rv0, re0, rdy1, busy1, rv1, re1, rdy2, busy2, rv2, re2;
  logic [63:0] ra0, rb0, aa0, ab0, ra1, rb1, aa1, ab1;
  logic [7:0]  ra2, rb2, aa2, ab2;
  logic [31:0] lc0, lc1, lc2;

  joltage_stream u_dut0 (
    .clk(clk), .rst(rst), .clear(clear), .s_valid(s_valid[0]), .s_digit(s_digit), .s_last(s_last),
    .s_ready(rdy0), .busy(busy0), .res_valid(rv0), .res_a(ra0), .res_b(rb0), .res_err(re0),
    .acc_a(aa0), .acc_b(ab0), .line_cnt(lc0));

  joltage_stream #(.MAX_LEN(16)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .s_valid(s_valid[1]), .s_digit(s_digit), .s_last(s_last),
    .s_ready(rdy1), .busy(busy1), .res_valid(rv1), .res_a(ra1), .res_b(rb1), .res_err(re1),
    .acc_a(aa1), .acc_b(ab1), .line_cnt(lc1));

  joltage_stream #(.MAX_LEN(16), .K_A(2), .K_B(2), .ACC_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear), .s_valid(s_valid[2]), .s_digit(s_digit), .s_last(s_last),
    .s_ready(rdy2), .busy(busy2), .res_valid(rv2), .res_a(ra2), .res_b(rb2), .res_err(re2),
    .acc_a(aa2), .acc_b(ab2), .line_cnt(lc2));

  int sel_mon = 0;
  logic mon_rdy, mon_busy, mon_rv, mon_err;
  logic [63:0] mon_a, mon_b, mon_acc_a, mon_acc_b;
  logic [31:0] mon_cnt;

  always_comb begin
    case (sel_mon)
      0: begin
        mon_rdy = rdy0; mon_busy = busy0; mon_rv = rv0; mon_err = re0;
        mon_a = ra0; mon_b = rb0; mon_acc_a = aa0; mon_acc_b = ab0; mon_cnt = lc0;
      end
      1: begin
        mon_rdy = rdy1; mon_busy = busy1; mon_rv = rv1; mon_err = re1;
        mon_a = ra1; mon_b = rb1; mon_acc_a = aa1; mon_acc_b = ab1; mon_cnt = lc1;
      end
      default: begin
        mon_rdy = rdy2; mon_busy = busy2; mon_rv = rv2; mon_err = re2;
        mon_a = {56'd0, ra2}; mon_b = {56'd0, rb2};
        mon_acc_a = {56'd0, aa2}; mon_acc_b = {56'd0, ab2}; mon_cnt = lc2;
      end
    endcase
  end

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [3:0]  cur_line[$];
  int          n_vec = 0;
  int          n_miss = 0;
  logic [63:0] m_acc_a, m_acc_b;
  logic [31:0] m_cnt;

  // Greedy reference: leftmost maximum within each legal window.
  function automatic logic [63:0] model_max(input int k);
    logic [63:0] v = 64'd0;
    int pos = 0;
    int n = cur_line.size();
    for (int j = 0; j < k; j++) begin
      int best = pos;
      for (int q = pos; q <= n - k + j; q++) if (cur_line[q] > cur_line[best]) best = q;
      v = v * 64'd10 + 64'(cur_line[best]);
      pos = best + 1;
    end
    return v;
  endfunction

  task automatic load_str(input string s);
    cur_line.delete();
    for (int i = 0; i < s.len(); i++) cur_line.push_back(4'(s[i] - 8'd48));
  endtask

  task automatic load_rand(input int n);
    cur_line.delete();
    for (int i = 0; i < n; i++) cur_line.push_back(4'($urandom_range(0, 9)));
  endtask

  // Returns at the first falling edge after the last beat is accepted.
  task automatic send_line(input bit gaps, input bit clr_first);
    int w = 0;
    @(negedge clk);
    while (mon_rdy !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    if (mon_rdy !== 1'b1) begin
      n_vec++; n_miss++;
      $display("FAIL send_ready_timeout: s_ready=%b required 1", mon_rdy);
    end
    for (int i = 0; i < cur_line.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 3'b000;
        @(negedge clk);
      end
      s_valid = 3'b000;
      s_valid[sel_mon] = 1'b1;
      s_digit = cur_line[i];
      s_last  = (i == cur_line.size() - 1);
      clear   = clr_first && (i == 0);
      @(negedge clk);
    end
    s_valid = 3'b000;
    s_last  = 1'b0;
    clear   = 1'b0;
  endtask

  task automatic wait_res(input int c0, output logic [63:0] a, output logic [63:0] b,
                          output logic err, output int cyc, output bit rdy_hi);
    cyc = c0;
    rdy_hi = 1'b0;
    while (mon_rv !== 1'b1 && cyc < 300) begin
      if (mon_rdy !== 1'b0) rdy_hi = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (mon_rdy !== 1'b0) rdy_hi = 1'b1;
    a = mon_a; b = mon_b; err = mon_err;
    if (mon_rv !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset;
    sel_mon = 0;
    rst = 1'b1; clear = 1'b0; s_valid = 3'b000; s_digit = 4'd0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (mon_rdy !== 1'b1) begin n_miss++; $display("FAIL reset_s_ready: got %b expected 1", mon_rdy); end
    n_vec++; if (mon_busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b expected 0", mon_busy); end
    n_vec++; if (mon_rv !== 1'b0) begin n_miss++; $display("FAIL reset_res_valid: got %b expected 0", mon_rv); end
    n_vec++; if (mon_err !== 1'b0) begin n_miss++; $display("FAIL reset_res_err: got %b expected 0", mon_err); end
    n_vec++; if (mon_a !== 64'd0 || mon_b !== 64'd0) begin n_miss++; $display("FAIL reset_res: got %0d/%0d expected 0/0", mon_a, mon_b); end
    n_vec++; if (mon_acc_a !== 64'd0 || mon_acc_b !== 64'd0 || mon_cnt !== 32'd0) begin
      n_miss++; $display("FAIL reset_acc: got %0d/%0d/%0d expected 0/0/0", mon_acc_a, mon_acc_b, mon_cnt);
    end
    m_acc_a = 64'd0; m_acc_b = 64'd0; m_cnt = 32'd0;
  endtask

  task automatic test_lines;
    string       lines[4] = '{"987654321111111", "811111111111119", "234234234234278", "818181911112111"};
    logic [63:0] ea[4] = '{64'd98, 64'd89, 64'd78, 64'd92};
    logic [63:0] eb[4] = '{64'd987654321111, 64'd811111111119, 64'd434234234278, 64'd888911112111};
    logic [63:0] ga, gb;
    logic ge;
    int cyc;
    bit rh;
    exp_t e;
    sel_mon = 0;
    for (int i = 0; i < 4; i++) begin
      load_str(lines[i]);
      sb_q.push_back('{ea[i], eb[i], 1'b0});
      send_line(1'b0, 1'b0);
      wait_res(1, ga, gb, ge, cyc, rh);
      e = sb_q.pop_front();
      n_vec++; if (cyc < 0) begin n_miss++; $display("FAIL lines_timeout: line %0d no res_valid", i); end
      n_vec++; if (ga !== e.a) begin n_miss++; $display("FAIL lines_res_a: line %0d got %0d expected %0d", i, ga, e.a); end
      n_vec++; if (gb !== e.b) begin n_miss++; $display("FAIL lines_res_b: line %0d got %0d expected %0d", i, gb, e.b); end
      n_vec++; if (ge !== e.err) begin n_miss++; $display("FAIL lines_res_err: line %0d got %b expected %b", i, ge, e.err); end
    end
    @(negedge clk);
    n_vec++; if (mon_acc_a !== 64'd357) begin n_miss++; $display("FAIL lines_acc_a: got %0d expected 357", mon_acc_a); end
    n_vec++; if (mon_acc_b !== 64'd3121910778619) begin n_miss++; $display("FAIL lines_acc_b: got %0d expected 3121910778619", mon_acc_b); end
    n_vec++; if (mon_cnt !== 32'd4) begin n_miss++; $display("FAIL lines_cnt: got %0d expected 4", mon_cnt); end
    m_acc_a = 64'd357; m_acc_b = 64'd3121910778619; m_cnt = 32'd4;
  endtask

  task automatic test_timing;
    logic [63:0] ga, gb;
    logic ge;
    int cyc;
    bit rh;
    exp_t e;
    sel_mon = 0;
    load_str("987654321111111");
    sb_q.push_back('{64'd98, 64'd987654321111, 1'b0});
    send_line(1'b0, 1'b0);
    n_vec++; if (mon_rdy !== 1'b0 || mon_busy !== 1'b1) begin
      n_miss++; $display("FAIL timing_load: s_ready=%b busy=%b expected 0/1", mon_rdy, mon_busy);
    end
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    wait_res(3, ga, gb, ge, cyc, rh);
    e = sb_q.pop_front();
    n_vec++; if (cyc != 15) begin n_miss++; $display("FAIL timing_latency: got %0d expected 15", cyc); end
    n_vec++; if (rh) begin n_miss++; $display("FAIL timing_ready_low: s_ready seen high, expected low"); end
    n_vec++; if (ga !== e.a || gb !== e.b || ge !== e.err) begin
      n_miss++; $display("FAIL timing_res: got %0d/%0d/%b expected %0d/%0d/%b", ga, gb, ge, e.a, e.b, e.err);
    end
    m_acc_a += e.a; m_acc_b += e.b; m_cnt += 32'd1;
    @(negedge clk);
    n_vec++; if (mon_rdy !== 1'b1) begin n_miss++; $display("FAIL timing_ready_back: got %b expected 1", mon_rdy); end
    n_vec++; if (mon_acc_a !== m_acc_a || mon_acc_b !== m_acc_b || mon_cnt !== m_cnt) begin
      n_miss++; $display("FAIL timing_clear_ignored: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         mon_acc_a, mon_acc_b, mon_cnt, m_acc_a, m_acc_b, m_cnt);
    end
  endtask

  task automatic test_short;
    logic [63:0] ga, gb;
    logic ge;
    int cyc;
    bit rh;
    exp_t e;
    sel_mon = 0;
    load_str("12345");
    sb_q.push_back('{64'd0, 64'd0, 1'b1});
    send_line(1'b0, 1'b0);
    wait_res(1, ga, gb, ge, cyc, rh);
    e = sb_q.pop_front();
    n_vec++; if (cyc != 2) begin n_miss++; $display("FAIL short_latency: got %0d expected 2", cyc); end
    n_vec++; if (ge !== e.err) begin n_miss++; $display("FAIL short_err: got %b expected %b", ge, e.err); end
    n_vec++; if (ga !== e.a || gb !== e.b) begin n_miss++; $display("FAIL short_res: got %0d/%0d expected 0/0", ga, gb); end
    m_cnt += 32'd1;
    @(negedge clk);
    n_vec++; if (mon_acc_a !== m_acc_a || mon_acc_b !== m_acc_b || mon_cnt !== m_cnt) begin
      n_miss++; $display("FAIL short_acc: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         mon_acc_a, mon_acc_b, mon_cnt, m_acc_a, m_acc_b, m_cnt);
    end
  endtask

  task automatic test_clear;
    logic [63:0] ga, gb;
    logic ge;
    int cyc;
    bit rh;
    exp_t e;
    sel_mon = 0;
    load_str("811111111111119");
    sb_q.push_back('{64'd89, 64'd811111111119, 1'b0});
    send_line(1'b0, 1'b1);
    wait_res(1, ga, gb, ge, cyc, rh);
    e = sb_q.pop_front();
    n_vec++; if (cyc < 0 || ga !== e.a || gb !== e.b || ge !== e.err) begin
      n_miss++; $display("FAIL clear_beat_res: cyc %0d got %0d/%0d/%b expected %0d/%0d/%b", cyc, ga, gb, ge, e.a, e.b, e.err);
    end
    @(negedge clk);
    n_vec++; if (mon_acc_a !== 64'd89 || mon_acc_b !== 64'd811111111119 || mon_cnt !== 32'd1) begin
      n_miss++; $display("FAIL clear_with_beat: got %0d/%0d/%0d expected 89/811111111119/1", mon_acc_a, mon_acc_b, mon_cnt);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_vec++; if (mon_acc_a !== 64'd0 || mon_acc_b !== 64'd0 || mon_cnt !== 32'd0) begin
      n_miss++; $display("FAIL clear_idle: got %0d/%0d/%0d expected 0/0/0", mon_acc_a, mon_acc_b, mon_cnt);
    end
    m_acc_a = 64'd0; m_acc_b = 64'd0; m_cnt = 32'd0;
  endtask

  task automatic test_random;
    int lens[6] = '{12, 13, 40, 128, 0, 0};
    logic [63:0] ga, gb;
    logic ge;
    int cyc;
    bit rh;
    exp_t e;
    sel_mon = 0;
    lens[4] = $urandom_range(14, 60);
    lens[5] = $urandom_range(14, 60);
    for (int i = 0; i < 6; i++) begin
      load_rand(lens[i]);
      sb_q.push_back('{model_max(2), model_max(12), 1'b0});
      send_line(1'b1, 1'b0);
      wait_res(1, ga, gb, ge, cyc, rh);
      e = sb_q.pop_front();
      n_vec++; if (cyc != lens[i] - 2 + 2) begin n_miss++; $display("FAIL rand_latency: N=%0d got %0d expected %0d", lens[i], cyc, lens[i]); end
      n_vec++; if (ga !== e.a) begin n_miss++; $display("FAIL rand_res_a: N=%0d got %0d expected %0d", lens[i], ga, e.a); end
      n_vec++; if (gb !== e.b) begin n_miss++; $display("FAIL rand_res_b: N=%0d got %0d expected %0d", lens[i], gb, e.b); end
      n_vec++; if (ge !== e.err) begin n_miss++; $display("FAIL rand_res_err: N=%0d got %b expected %b", lens[i], ge, e.err); end
      m_acc_a += e.a; m_acc_b += e.b; m_cnt += 32'd1;
    end
    @(negedge clk);
    n_vec++; if (mon_acc_a !== m_acc_a || mon_acc_b !== m_acc_b || mon_cnt !== m_cnt) begin
      n_miss++; $display("FAIL rand_acc: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         mon_acc_a, mon_acc_b, mon_cnt, m_acc_a, m_acc_b, m_cnt);
    end
  endtask

  task automatic test_overflow;
    logic [63:0] ga, gb, ea, eb;
    logic ge;
    int cyc;
    bit rh;
    exp_t e;
    sel_mon = 1;
    load_rand(16);
    ea = model_max(2); eb = model_max(12);
    sb_q.push_back('{ea, eb, 1'b0});
    send_line(1'b0, 1'b0);
    wait_res(1, ga, gb, ge, cyc, rh);
    e = sb_q.pop_front();
    n_vec++; if (cyc < 0 || ga !== e.a || gb !== e.b || ge !== e.err) begin
      n_miss++; $display("FAIL ovf_full_line: cyc %0d got %0d/%0d/%b expected %0d/%0d/%b", cyc, ga, gb, ge, e.a, e.b, e.err);
    end
    load_rand(20);
    sb_q.push_back('{64'd0, 64'd0, 1'b1});
    send_line(1'b0, 1'b0);
    wait_res(1, ga, gb, ge, cyc, rh);
    e = sb_q.pop_front();
    n_vec++; if (cyc != 2) begin n_miss++; $display("FAIL ovf_latency: got %0d expected 2", cyc); end
    n_vec++; if (ge !== e.err || ga !== e.a || gb !== e.b) begin
      n_miss++; $display("FAIL ovf_res: got %0d/%0d/%b expected 0/0/1", ga, gb, ge);
    end
    @(negedge clk);
    n_vec++; if (mon_acc_a !== ea || mon_acc_b !== eb || mon_cnt !== 32'd2) begin
      n_miss++; $display("FAIL ovf_acc: got %0d/%0d/%0d expected %0d/%0d/2", mon_acc_a, mon_acc_b, mon_cnt, ea, eb);
    end
  endtask

  task automatic test_wrap;
`ifdef JOLTAGE_SAT_EN
    logic [63:0] ex[3] = '{64'd99, 64'd198, 64'd255};
`else
    logic [63:0] ex[3] = '{64'd99, 64'd198, 64'd41};
`endif
    logic [63:0] ga, gb;
    logic ge;
    int cyc;
    bit rh;
    exp_t e;
    sel_mon = 2;
    for (int i = 0; i < 3; i++) begin
      load_str("99");
      sb_q.push_back('{64'd99, 64'd99, 1'b0});
      send_line(1'b0, 1'b0);
      wait_res(1, ga, gb, ge, cyc, rh);
      e = sb_q.pop_front();
      n_vec++; if (cyc != 2 || ga !== e.a || gb !== e.b || ge !== e.err) begin
        n_miss++; $display("FAIL wrap_res: line %0d cyc %0d got %0d/%0d/%b expected 2 %0d/%0d/%b", i, cyc, ga, gb, ge, e.a, e.b, e.err);
      end
      @(negedge clk);
      n_vec++; if (mon_acc_a !== ex[i] || mon_acc_b !== ex[i]) begin
        n_miss++; $display("FAIL wrap_acc: line %0d got %0d/%0d expected %0d", i, mon_acc_a, mon_acc_b, ex[i]);
      end
    end
  endtask

  task automatic test_rst_mid;
    logic [63:0] ga, gb;
    logic ge;
    int cyc;
    bit rh;
    exp_t e;
    sel_mon = 0;
    load_str("811111111111119");
    send_line(1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (mon_rdy !== 1'b1 || mon_busy !== 1'b0 || mon_rv !== 1'b0) begin
      n_miss++; $display("FAIL rst_mid_ctrl: ready/busy/valid %b/%b/%b expected 1/0/0", mon_rdy, mon_busy, mon_rv);
    end
    n_vec++; if (mon_acc_a !== 64'd0 || mon_cnt !== 32'd0 || mon_a !== 64'd0) begin
      n_miss++; $display("FAIL rst_mid_regs: acc_a/cnt/res_a %0d/%0d/%0d expected 0/0/0", mon_acc_a, mon_cnt, mon_a);
    end
    load_str("987654321111111");
    sb_q.push_back('{64'd98, 64'd987654321111, 1'b0});
    send_line(1'b0, 1'b0);
    wait_res(1, ga, gb, ge, cyc, rh);
    e = sb_q.pop_front();
    n_vec++; if (cyc != 15 || ga !== e.a || gb !== e.b || ge !== e.err) begin
      n_miss++; $display("FAIL rst_mid_res: cyc %0d got %0d/%0d/%b expected 15 %0d/%0d/%b", cyc, ga, gb, ge, e.a, e.b, e.err);
    end
    @(negedge clk);
    n_vec++; if (mon_acc_a !== 64'd98 || mon_acc_b !== 64'd987654321111 || mon_cnt !== 32'd1) begin
      n_miss++; $display("FAIL rst_mid_acc: got %0d/%0d/%0d expected 98/987654321111/1", mon_acc_a, mon_acc_b, mon_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lines();
    test_timing();
    test_short();
    test_clear();
    test_random();
    test_overflow();
    test_wrap();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_miss);
    $fatal(1, "watchdog");
  end
endmodule
